// File: rtl/servo_pkg.sv
// Shared constants and types for the servo pulse generator/decoder pair.
// Timing defaults assume a 100 MHz clock (1.0 / 1.5 / 2.0 ms pulses).
package servo_pkg;

   localparam int unsigned DEF_CW        = 22;
   localparam int unsigned DEF_T_FWD     = 100_000;
   localparam int unsigned DEF_T_BRK     = 150_000;
   localparam int unsigned DEF_T_REV     = 200_000;
   localparam int unsigned DEF_TOL       = 10_000;
   localparam int unsigned DEF_T_MAXHI   = 250_000;
   localparam int unsigned DEF_T_TIMEOUT = 2_100_000;

   // Decoder FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOW    = 2'd1,
      HIGH   = 2'd2,
      DECODE = 2'd3
   } dec_state_t;

   // True when |w - t| <= tol, evaluated without signed arithmetic
   function automatic logic in_window(input logic [31:0] w,
                                      input logic [31:0] t,
                                      input logic [31:0] tol);
      if (w >= t)
         return (w - t) <= tol;
      else
         return (t - w) <= tol;
   endfunction

endpackage

// File: rtl/servo_pulse_decoder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with registered
// rise/fall strobes derived from the synchronized level.
// The chain resets to 1 so that a reset never fabricates a rising edge:
// a pulse already high when reset releases produces no rise strobe.
module sync_edge
   import servo_pkg::*;
#(
   parameter int unsigned STAGES = 2
)(
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_reg;
   logic              level_d_reg;
   logic              rise_reg;
   logic              fall_reg;

   // Synchronizer shift chain; the last stage is the usable level
   always_ff @(posedge clk) begin
      if (reset)
         chain_reg <= '1;
      else
         chain_reg <= {chain_reg[STAGES-2:0], din};
   end

   // Edge strobes, registered one cycle after the synchronized level changes
   always_ff @(posedge clk) begin
      if (reset) begin
         level_d_reg <= 1'b1;
         rise_reg    <= 1'b0;
         fall_reg    <= 1'b0;
      end else begin
         level_d_reg <= chain_reg[STAGES-1];
         rise_reg    <=  chain_reg[STAGES-1] & ~level_d_reg;
         fall_reg    <= ~chain_reg[STAGES-1] &  level_d_reg;
      end
   end

   assign level = chain_reg[STAGES-1];
   assign rise  = rise_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo pulse decoder: measures the high time of an incoming servo pulse
// train, classifies it as forward / brake / reverse, and flags malformed
// pulses (err strobe) and loss of signal (lost level).
// Results are loaded on the fall edge seen in HIGH; DECODE is the single
// cycle in which the fresh width/direction/brake and the strobe are shown.
module servo_pulse_decoder
   import servo_pkg::*;
#(
   parameter int unsigned CW        = DEF_CW,
   parameter int unsigned T_FWD     = DEF_T_FWD,
   parameter int unsigned T_BRK     = DEF_T_BRK,
   parameter int unsigned T_REV     = DEF_T_REV,
   parameter int unsigned TOL       = DEF_TOL,
   parameter int unsigned T_MAXHI   = DEF_T_MAXHI,
   parameter int unsigned T_TIMEOUT = DEF_T_TIMEOUT
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          pwm_in,
   output logic          direction,
   output logic          brake,
   output logic [CW-1:0] width,
   output logic          valid,
   output logic          err,
   output logic          lost
);

   localparam logic [CW-1:0] MAXHI_C   = CW'(T_MAXHI);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(T_TIMEOUT);

   logic          sync_level;
   logic          sync_rise;
   logic          sync_fall;

   dec_state_t    state_reg, state_next;
   logic [CW-1:0] hi_cnt_reg, hi_cnt_next;
   logic [CW-1:0] hi_plus;
   logic [CW-1:0] width_reg, width_next;
   logic          dir_reg, dir_next;
   logic          brk_reg, brk_next;
   logic          valid_reg, valid_next;
   logic          err_reg, err_next;
   logic [CW-1:0] loss_cnt_reg;
   logic          is_fwd, is_brk, is_rev;

   sync_edge #(
      .STAGES (2)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (pwm_in),
      .level (sync_level),
      .rise  (sync_rise),
      .fall  (sync_fall)
   );

   // Classifier: hi_plus is the high time including the current (fall) cycle
   always_comb begin
      hi_plus = hi_cnt_reg + CW'(1);
      is_fwd  = in_window(32'(hi_plus), T_FWD, TOL);
      is_brk  = in_window(32'(hi_plus), T_BRK, TOL);
      is_rev  = in_window(32'(hi_plus), T_REV, TOL);
   end

   // FSM next-state, hi-counter and output-register next values
   always_comb begin
      state_next  = state_reg;
      hi_cnt_next = hi_cnt_reg;
      width_next  = width_reg;
      dir_next    = dir_reg;
      brk_next    = brk_reg;
      valid_next  = 1'b0;
      err_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            // Only measure pulses whose rising edge we actually saw
            if (!sync_level)
               state_next = LOW;
         end
         LOW: begin
            if (sync_rise) begin
               hi_cnt_next = '0;
               state_next  = HIGH;
            end
         end
         HIGH: begin
            if (sync_fall) begin
               width_next = hi_plus;
               state_next = DECODE;
               if (is_fwd) begin
                  dir_next   = 1'b0;
                  brk_next   = 1'b0;
                  valid_next = 1'b1;
               end else if (is_rev) begin
                  dir_next   = 1'b1;
                  brk_next   = 1'b0;
                  valid_next = 1'b1;
               end else if (is_brk) begin
                  brk_next   = 1'b1;
                  valid_next = 1'b1;
               end else begin
                  err_next   = 1'b1;
               end
            end else if (hi_plus == MAXHI_C) begin
               // Stuck high: abandon, then insist on a low before measuring again
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               hi_cnt_next = hi_plus;
            end
         end
         DECODE: begin
            state_next = LOW;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state, hi-counter and decoded output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         hi_cnt_reg <= '0;
         width_reg  <= '0;
         dir_reg    <= 1'b0;
         brk_reg    <= 1'b1;
         valid_reg  <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         hi_cnt_reg <= hi_cnt_next;
         width_reg  <= width_next;
         dir_reg    <= dir_next;
         brk_reg    <= brk_next;
         valid_reg  <= valid_next;
         err_reg    <= err_next;
      end
   end

   // Loss-of-signal counter: saturating, cleared together with the valid strobe
   always_ff @(posedge clk) begin
      if (reset)
         loss_cnt_reg <= TIMEOUT_C;
      else if (valid_next)
         loss_cnt_reg <= '0;
      else if (loss_cnt_reg != TIMEOUT_C)
         loss_cnt_reg <= loss_cnt_reg + CW'(1);
   end

   assign lost      = (loss_cnt_reg == TIMEOUT_C);
   assign direction = dir_reg;
   assign brake     = brk_reg | lost;
   assign width     = width_reg;
   assign valid     = valid_reg;
   assign err       = err_reg;

endmodule
